mem_access_unit: RTL
====================

# mem_access_unit

Core-side initiator for the RT core's single-port scratch RAM. It accepts one byte-addressed load/store request at a time over a valid/ready handshake and converts it to a word address. It drives the RAM's addr/we/data port, waits out the RAM's registered read latency, and returns a response over a second valid/ready handshake. It sits between the RT core datapath and `single_port_ram_inst`, which is instantiated outside this block.

## Interface
Parameters:
- `ADDR_WIDTH`, 9, RAM word-address width.
- `DATA_WIDTH`, 32, data word width.
- `RD_LATENCY`, 1, RAM cycles from the addr-sampling edge to valid q (≥1).

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in DATA_WIDTH: store data.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes the response.
- `resp_rdata` out DATA_WIDTH: load data; 0 for stores and errors.
- `resp_err` out 2: 00 ok, 01 misaligned, 10 out of range.
- `ram_addr` out ADDR_WIDTH: word address, `req_addr[ADDR_WIDTH+1:2]`.
- `ram_we` out 1: RAM write strobe.
- `ram_data` out DATA_WIDTH: RAM write data.
- `ram_q` in DATA_WIDTH: RAM read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_ready=1`.
  - On `req_valid&&req_ready`: latch we, addr, and wdata.
  - If `req_addr[1:0]!=0`: set err=01, go to RESP. No RAM access.
  - Else if the range check fails (see Configuration): set err=10, go to RESP.
  - Else: go to ISSUE.
- **ISSUE**
  - `ram_addr` comes from the latched address.
  - For a store: `ram_we=1` for exactly this cycle, `ram_data`=latched wdata, then go to RESP.
  - For a load: `ram_we=0`, load the latency counter with RD_LATENCY, then go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, capture `ram_q` into `resp_rdata`, then go to RESP.
- **RESP**
  - `resp_valid=1`; rdata and err are held stable until `resp_ready`.
  - On handshake, go to IDLE.
- `req_ready` is low outside IDLE. There is only ever one outstanding request.
- `ram_addr` and `ram_data` hold their last values outside ISSUE. `ram_we` is 0 outside ISSUE.
- `resp_rdata` is 0 for stores and errors.

## Timing
- Reset values:
  - state IDLE.
  - `req_ready=0`; it goes to 1 on the first posedge after `rst_n` rises.
  - `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `ram_addr=0`, `ram_we=0`, `ram_data=0`.
- Cycle numbering: request accepted in cycle 0.
- Load: ISSUE in cycle 1, `resp_valid` in cycle 2+RD_LATENCY. With the default that is cycle 3.
- Store: `ram_we` high in cycle 1, `resp_valid` in cycle 2.
- Error: `resp_valid` in cycle 1.
- The response handshake in cycle N gives `req_ready=1` in cycle N+1. There is no same-cycle turnaround.
- Best-case load throughput is one per 4 cycles.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronously), including `ram_we`.
  - Any pending response is discarded.
- `req_*` inputs are ignored while `req_ready=0`. Their changes have no effect.

## Configuration
- Macro `MEM_ACCESS_BOUNDS_CHECK_EN`.
- Defined: any nonzero `req_addr[31:ADDR_WIDTH+2]` gives err=10, with no RAM access.
- Undefined: the upper address bits are ignored and the address wraps modulo 2^ADDR_WIDTH words. err=10 is never produced.
- Misalignment checking is always present.

## Structure
- Package `mem_access_pkg`:
  - FSM state enum `mau_state_t`.
  - Error code constants `MAU_ERR_OK`, `MAU_ERR_MISALIGN`, `MAU_ERR_RANGE`.
- No sub-module: the latency counter and FSM are inline.
- The RAM is instantiated by the parent.

## Test plan
- **Store:** store 0xDEADBEEF to byte addr 0x004.
  - `ram_addr=1` and `ram_we=1` for exactly cycle 1.
  - `resp_valid` in cycle 2 with err=00, rdata=0.
- **Load:** load from 0x004 after the store above.
  - `resp_valid` in cycle 3 with `resp_rdata=0xDEADBEEF`, err=00.
  - `ram_we` stays 0 throughout.
- **Misaligned load:** load from 0x006.
  - `resp_valid` in cycle 1 with err=01, rdata=0.
  - No ISSUE cycle and no `ram_we`.
- **Out-of-range load:** load from 0x800.
  - With the macro: err=10 in cycle 1.
  - Without the macro: `ram_addr=0` in cycle 1 and data from word 0 in cycle 3.
- **Backpressure:** hold `resp_ready=0` for 5 cycles during a load response.
  - `resp_valid`, `resp_rdata` and `resp_err` stay stable, and `req_ready` stays 0.
  - After the handshake, `req_ready=1` in the next cycle.
- **Reset mid-load:** assert `rst_n=0` in the WAIT cycle.
  - All outputs are 0 immediately and no response appears.
  - `req_ready=1` one posedge after release.
  - A following load from 0x004 returns 0xDEADBEEF (RAM contents are preserved).

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the scratch-RAM access unit: FSM state encoding and response error codes.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } mau_state_t;

  localparam logic [1:0] MAU_ERR_OK       = 2'b00;
  localparam logic [1:0] MAU_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] MAU_ERR_RANGE    = 2'b10;

endpackage

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for the core's single-port scratch RAM.
// Define MEM_ACCESS_BOUNDS_CHECK_EN to reject addresses beyond the RAM instead of wrapping.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int CNT_W = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mau_state_t       state;
  logic             op_we;
  logic [CNT_W-1:0] cnt;
  logic             misaligned;
  logic             out_of_range;

  assign misaligned = (req_addr[1:0] != 2'b00);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  assign out_of_range = |req_addr[31:ADDR_WIDTH+2];
`else
  // Upper address bits are deliberately dropped so the address wraps within the RAM.
  logic unused_upper;
  assign unused_upper = ^req_addr[31:ADDR_WIDTH+2];
  assign out_of_range = 1'b0;
`endif

  // NOTE: every state and output register is assigned with <= so all of them
  // update together from the values they held before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= MAU_ERR_OK;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_data   <= '0;
      op_we      <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            op_we      <= req_we;
            resp_rdata <= '0;
            resp_err   <= MAU_ERR_OK;
            if (misaligned) begin
              resp_err   <= MAU_ERR_MISALIGN;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (out_of_range) begin
              resp_err   <= MAU_ERR_RANGE;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              // Registered here so the RAM port is already driven during ISSUE.
              ram_addr <= req_addr[ADDR_WIDTH+1:2];
              ram_we   <= req_we;
              if (req_we) ram_data <= req_wdata;
              state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          ram_we <= 1'b0;
          if (op_we) begin
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt   <= CNT_LOAD;
            state <= WAIT;
          end
        end

        WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            resp_rdata <= ram_q;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
